// File: rtl/spi_shift_engine.sv
// SPI mode-0 master shift engine driven by an external sck_in divider tick.
// Define SPI_LOOPBACK_EN to route mosi back into the receive shifter instead of miso.
`timescale 1ns/1ps
module spi_shift_engine #(
  parameter int DATA_W = 8
) (
  input  logic              clk_100,
  input  logic              a_rst,
  input  logic              sck_in,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic              cs_n
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t              state_reg, state_next;
  logic                sck_d_reg;
  logic [DATA_W-1:0]   tx_shift_reg, tx_shift_next;
  logic [DATA_W-1:0]   rx_shift_reg, rx_shift_next;
  logic [DATA_W-1:0]   rx_data_reg, rx_data_next;
  logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic                cs_n_reg, cs_n_next;
  logic                sclk_reg, sclk_next;
  logic                rx_valid_reg, rx_valid_next;
  logic                rise, fall;
  logic                miso_eff;

  assign rise = sck_in & ~sck_d_reg;
  assign fall = ~sck_in & sck_d_reg;

`ifdef SPI_LOOPBACK_EN
  assign miso_eff = mosi;
`else
  assign miso_eff = miso;
`endif

  // mosi is gated so a stale shifter MSB never leaks while deselected
  assign mosi     = ~cs_n_reg & tx_shift_reg[DATA_W-1];
  assign tx_ready = (state_reg == IDLE);
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign sclk     = sclk_reg;
  assign cs_n     = cs_n_reg;

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    cs_n_next     = cs_n_reg;
    sclk_next     = 1'b0;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (tx_valid) begin
          tx_shift_next = tx_data;
          rx_shift_next = '0;
          bit_cnt_next  = '0;
          cs_n_next     = 1'b0;
          state_next    = SETUP;
        end
      end
      SETUP: begin
        // Waiting for a fall gives mosi at least half an sck period of setup
        if (fall) state_next = SHIFT;
      end
      SHIFT: begin
        sclk_next = sck_in;
        if (rise) begin
          rx_shift_next = {rx_shift_reg[DATA_W-2:0], miso_eff};
          bit_cnt_next  = bit_cnt_reg + 1'b1;
        end else if (fall) begin
          if (bit_cnt_reg == CNT_W'(DATA_W)) begin
            state_next = DONE;
          end else begin
            tx_shift_next = tx_shift_reg << 1;
          end
        end
      end
      DONE: begin
        cs_n_next     = 1'b1;
        rx_data_next  = rx_shift_reg;
        rx_valid_next = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      sck_d_reg    <= 1'b0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      bit_cnt_reg  <= '0;
      cs_n_reg     <= 1'b1;
      sclk_reg     <= 1'b0;
      rx_valid_reg <= 1'b0;
    end else begin
      sck_d_reg    <= sck_in;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      bit_cnt_reg  <= bit_cnt_next;
      cs_n_reg     <= cs_n_next;
      sclk_reg     <= sclk_next;
      rx_valid_reg <= rx_valid_next;
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: a mode-0 slave model plus a bus monitor
// feed immediate-assertion checks; sck_in comes from a divide-by-4 generator.
`timescale 1ns/1ps
module tb_spi_shift_engine;

`ifdef SPI_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic       clk_100 = 1'b0;
  logic       a_rst = 1'b1;
  logic       sck_in = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       miso;
  logic       mosi;
  logic       sclk;
  logic       cs_n;

  int checks = 0;
  int failures = 0;

  spi_shift_engine #(.DATA_W(8)) dut (
    .clk_100 (clk_100),
    .a_rst   (a_rst),
    .sck_in  (sck_in),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .miso    (miso),
    .mosi    (mosi),
    .sclk    (sclk),
    .cs_n    (cs_n)
  );

  always #5 clk_100 = ~clk_100;

  // sck divider: period of 4 clk_100 cycles, updated away from the active edge
  logic [1:0] div = 2'd0;
  always @(negedge clk_100) begin
    div = div + 2'd1;
    sck_in = div[1];
  end

  // Slave model and bus monitor
  logic [7:0] slave_word = 8'h00;
  logic [7:0] slave_sr = 8'h00;
  logic       miso_zero = 1'b0;
  logic       prev_sclk = 1'b0;
  logic       prev_cs = 1'b1;
  logic       prev_rxv = 1'b0;
  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] rx_prev = 8'h00;
  int rise_total = 0;
  int rise_xfer = 0;
  int hi_run = 0;
  int last_hi_run = 0;
  int rxv_cnt = 0;
  int rxv_pulses = 0;

  assign miso = miso_zero ? 1'b0 : slave_sr[7];

  always @(negedge clk_100) begin
    if (prev_cs && !cs_n) begin
      slave_sr = slave_word;
      mosi_cap = 8'h00;
      rise_xfer = 0;
      last_hi_run = hi_run;
    end
    if (cs_n) hi_run = hi_run + 1;
    else hi_run = 0;
    if (sclk && !prev_sclk) begin
      mosi_cap = {mosi_cap[6:0], mosi};
      rise_total = rise_total + 1;
      rise_xfer = rise_xfer + 1;
    end
    if (!sclk && prev_sclk) slave_sr = {slave_sr[6:0], 1'b0};
    if (rx_valid) begin
      rxv_cnt = rxv_cnt + 1;
      rx_prev = rx_last;
      rx_last = rx_data;
    end
    if (rx_valid && !prev_rxv) rxv_pulses = rxv_pulses + 1;
    prev_sclk = sclk;
    prev_cs = cs_n;
    prev_rxv = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_100);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input bit hold, input string tag);
    int n = 0;
    tx_data = w;
    tx_valid = 1'b1;
    while (!tx_ready && n < 300) begin
      tick();
      n++;
    end
    check(tag, 32'(tx_ready), 32'd1);
    tick();
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int target, input string tag);
    int n = 0;
    while (rxv_cnt < target && n < 400) begin
      tick();
      n++;
    end
    check(tag, 32'(rxv_cnt >= target), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rxv;
    int base_pulse;
    int base_rise;
    int n;
    logic any_ready;

    // Reset state
    a_rst = 1'b1;
    tick(); tick(); tick();
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    a_rst = 1'b0;
    tick(); tick();

    // Single transfer: 0xA5 out, slave returns 0x3C
    base_rxv = rxv_cnt;
    base_pulse = rxv_pulses;
    slave_word = 8'h3C;
    send(8'hA5, 1'b0, "single_accept");
    check("single_cs_low", 32'(cs_n), 32'd0);
    wait_rx(base_rxv + 1, "single_done_timeout");
    check("single_mosi_bits", 32'(mosi_cap), 32'hA5);
    check("single_rises", 32'(rise_xfer), 32'd8);
    check("single_rx_data", 32'(rx_data), LB ? 32'hA5 : 32'h3C);
    check("single_rxv_cycles", 32'(rxv_cnt - base_rxv), 32'd1);
    check("single_rxv_pulses", 32'(rxv_pulses - base_pulse), 32'd1);
    check("single_cs_high", 32'(cs_n), 32'd1);
    check("single_mosi_idle", 32'(mosi), 32'd0);
    check("single_sclk_idle", 32'(sclk), 32'd0);

    // Back-to-back: 0xFF then 0x00 with tx_valid held
    base_rxv = rxv_cnt;
    base_rise = rise_total;
    slave_word = 8'hC3;
    send(8'hFF, 1'b1, "b2b_accept1");
    tx_data = 8'h00;
    tick();
    slave_word = 8'h81;
    n = 0;
    while (!tx_ready && n < 300) begin
      tick();
      n++;
    end
    check("b2b_second_ready", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0;
    check("b2b_cs_gap", 32'(last_hi_run), 32'd1);
    wait_rx(base_rxv + 2, "b2b_done_timeout");
    check("b2b_rxv_count", 32'(rxv_cnt - base_rxv), 32'd2);
    check("b2b_rises", 32'(rise_total - base_rise), 32'd16);
    check("b2b_rx_first", 32'(rx_prev), LB ? 32'hFF : 32'hC3);
    check("b2b_rx_second", 32'(rx_last), LB ? 32'h00 : 32'h81);
    check("b2b_mosi_second", 32'(mosi_cap), 32'h00);

    // Abort: asynchronous reset after the 3rd sclk rise
    base_rxv = rxv_cnt;
    slave_word = 8'hF0;
    send(8'hC7, 1'b0, "abort_accept");
    n = 0;
    while (rise_xfer < 3 && n < 300) begin
      tick();
      n++;
    end
    check("abort_reached_rise3", 32'(rise_xfer), 32'd3);
    #2;
    a_rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd0);
    tick();
    a_rst = 1'b0;
    #1;
    check("abort_tx_ready", 32'(tx_ready), 32'd1);
    for (int i = 0; i < 40; i++) tick();
    check("abort_no_rx_valid", 32'(rxv_cnt - base_rxv), 32'd0);
    check("abort_rx_data", 32'(rx_data), 32'h00);

    // Busy: tx_valid with 0x11 during the SHIFT of 0x22 is ignored
    base_rxv = rxv_cnt;
    slave_word = 8'h96;
    send(8'h22, 1'b0, "busy_accept");
    n = 0;
    while (rise_xfer < 2 && n < 300) begin
      tick();
      n++;
    end
    any_ready = 1'b0;
    tx_data = 8'h11;
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      any_ready = any_ready | tx_ready;
      tick();
    end
    tx_valid = 1'b0;
    check("busy_tx_ready_low", 32'(any_ready), 32'd0);
    wait_rx(base_rxv + 1, "busy_done_timeout");
    check("busy_mosi_bits", 32'(mosi_cap), 32'h22);
    check("busy_rx_data", 32'(rx_data), LB ? 32'h22 : 32'h96);
    for (int i = 0; i < 20; i++) tick();
    check("busy_no_extra_xfer", 32'(cs_n), 32'd1);
    check("busy_rxv_count", 32'(rxv_cnt - base_rxv), 32'd1);

    // Loopback: miso tied low
    base_rxv = rxv_cnt;
    miso_zero = 1'b1;
    send(8'h5A, 1'b0, "lb_accept");
    wait_rx(base_rxv + 1, "lb_done_timeout");
    check("lb_rx_data", 32'(rx_data), LB ? 32'h5A : 32'h00);
    check("lb_mosi_bits", 32'(mosi_cap), 32'h5A);
    miso_zero = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk_100 for all state, and a_rst, an asynchronous, active-high reset.
REQ-002 Parameter: DATA_W, default 8, bits per transfer; SHALL be >= 2.
REQ-003 clk_100  in  1  system clock; all state updates on its rising edge.
REQ-004 a_rst  in  1  asynchronous active-high reset.
REQ-005 sck_in  in  1  divided serial clock from the clock divider, synchronous to clk_100, idles low.
REQ-006 tx_data  in  DATA_W  word to transmit, MSB first.
REQ-007 tx_valid  in  1  tx_data is valid.
REQ-008 tx_ready  out  1  block can accept a word.
REQ-009 rx_data  out  DATA_W  last received word.
REQ-010 rx_valid  out  1  one-cycle pulse: rx_data has just been updated.
REQ-011 miso  in  1  serial data from slave.
REQ-012 mosi  out  1  serial data to slave.
REQ-013 sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-014 cs_n  out  1  active-low chip select.

Function
REQ-015 The block SHALL register sck_in each cycle into sck_d; rise = sck_in & !sck_d, fall = !sck_in & sck_d.
REQ-016 FSM states SHALL be IDLE, SETUP, SHIFT and DONE.
REQ-017 IDLE: tx_ready=1 only in IDLE; tx_valid&tx_ready loads tx_shift<=tx_data, clears bit_cnt and rx_shift, sets cs_n<=0, goes to SETUP (cs_n low 1 cycle after accept).
REQ-018 SETUP: the FSM SHALL wait for fall, then go to SHIFT; this guarantees >= half an sck period of MOSI setup before the first sclk rise.
REQ-019 SHIFT: sclk register SHALL follow sck_in (one-cycle lag); outside SHIFT, sclk SHALL be 0.
REQ-020 SHIFT, on rise: rx_shift <= {rx_shift[DATA_W-2:0], miso_eff}; bit_cnt <= bit_cnt+1.
REQ-021 SHIFT, on fall: if bit_cnt==DATA_W go to DONE, else tx_shift <= tx_shift<<1.
REQ-022 mosi SHALL equal tx_shift[DATA_W-1] while cs_n=0, and 0 otherwise.
REQ-023 DONE (one cycle): cs_n<=1, rx_data<=rx_shift, rx_valid<=1 for exactly one cycle, then IDLE.
REQ-024 Exactly DATA_W sclk rising edges SHALL occur per transfer.
REQ-025 bit_cnt width SHALL be $clog2(DATA_W+1); bit_cnt does not wrap within a transfer.
REQ-026 tx_valid outside IDLE SHALL be ignored with no side effects.
REQ-027 rx_valid has no backpressure; rx_data SHALL hold until the next DONE.
REQ-028 Back-to-back: with tx_valid held high, cs_n SHALL be high for exactly one cycle between transfers.
REQ-029 If sck_in stops toggling, the FSM SHALL wait indefinitely in its current state with outputs stable.

Reset
REQ-030 On a_rst, immediately and regardless of clk_100: state=IDLE, cs_n=1, sclk=0, mosi=0, rx_valid=0, rx_data=0, tx_ready=1, sck_d=0, shift registers and bit_cnt=0.
REQ-031 An a_rst asserted mid-transfer SHALL abort the transfer with no rx_valid pulse; the next word is accepted on the first cycle after release.

Configuration
REQ-032 Macro SPI_LOOPBACK_EN defined: miso_eff=mosi (internal loopback) and the miso pin is ignored.
REQ-033 Macro SPI_LOOPBACK_EN undefined: miso_eff=miso; no loopback logic is present.

Verification (sck_in from divider, period 4 clk_100 cycles, DATA_W=8)
REQ-034 Reset: a_rst pulse -> cs_n=1, sclk=0, mosi=0, tx_ready=1, rx_valid=0, rx_data=0x00.
REQ-035 Single transfer: tx_data=0xA5 accepted, slave model returns 0x3C -> mosi 1,0,1,0,0,1,0,1 sampled on 8 sclk rises; rx_data=0x3C; one rx_valid pulse; cs_n high after.
REQ-036 Back-to-back: tx 0xFF then 0x00 with tx_valid held -> cs_n high exactly 1 cycle between; two rx_valid pulses; 16 sclk rises total.
REQ-037 Abort: a_rst after 3rd sclk rise -> cs_n=1, sclk=0 same cycle; no rx_valid; tx_ready=1 after release.
REQ-038 Busy: tx_valid pulsed with 0x11 during SHIFT of 0x22 -> only 0x22 transmitted; tx_ready=0 throughout.
REQ-039 Loopback: tx 0x5A, miso tied 0 -> rx_data=0x5A with SPI_LOOPBACK_EN; 0x00 without.
